// File: rtl/led_blinker.sv
// Turns request strobes into N visible LED blinks with busy/done handshake.
// Define LED_BLINKER_QUEUE_EN to add a one-deep pending-request slot.
module led_blinker #(
   parameter int ON_MS        = 200,
   parameter int OFF_MS       = 200,
   parameter int CLK_FREQ_MHZ = 50,
   parameter int COUNT_W      = 4
) (
   input  logic               clk_50MHz,
   input  logic               rst_n,
   input  logic               req,
   input  logic [COUNT_W-1:0] req_count,
   output logic               led_out,
   output logic               busy,
   output logic               done
);

   localparam int ON_CYC  = ON_MS * CLK_FREQ_MHZ * 1000;
   localparam int OFF_CYC = OFF_MS * CLK_FREQ_MHZ * 1000;
   localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);
   localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYC - 1);
   localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [TMR_W-1:0]   r_timer;
   logic [TMR_W-1:0]   w_timer_nxt;
   logic [COUNT_W-1:0] r_remain;
   logic [COUNT_W-1:0] w_remain_nxt;
   logic [COUNT_W-1:0] w_remain_dec;
   logic               w_done_nxt;
   logic               w_req_ok;
   logic               r_led;
   logic               r_busy;
   logic               r_done;

`ifdef LED_BLINKER_QUEUE_EN
   logic               r_pend_vld;
   logic               w_pend_vld_nxt;
   logic [COUNT_W-1:0] r_pend_cnt;
   logic [COUNT_W-1:0] w_pend_cnt_nxt;
`endif

   assign w_req_ok     = req && (req_count != '0);
   assign w_remain_dec = r_remain - 1'b1;

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_remain_nxt = r_remain;
      w_done_nxt   = 1'b0;
`ifdef LED_BLINKER_QUEUE_EN
      w_pend_vld_nxt = r_pend_vld;
      w_pend_cnt_nxt = r_pend_cnt;
      // A request landing on the final OFF cycle overwrites the slot and is consumed below.
      if (w_req_ok && (r_state != S_IDLE)) begin
         w_pend_vld_nxt = 1'b1;
         w_pend_cnt_nxt = req_count;
      end
`endif
      case (r_state)
         S_IDLE: begin
            if (w_req_ok) begin
               w_remain_nxt = req_count;
               w_timer_nxt  = '0;
               w_state_nxt  = S_ON;
            end
         end
         S_ON: begin
            if (r_timer == ON_LAST) begin
               w_timer_nxt = '0;
               w_state_nxt = S_OFF;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_OFF: begin
            if (r_timer == OFF_LAST) begin
               w_timer_nxt  = '0;
               w_remain_nxt = w_remain_dec;
               if (w_remain_dec != '0) begin
                  w_state_nxt = S_ON;
               end else begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
`ifdef LED_BLINKER_QUEUE_EN
                  if (w_pend_vld_nxt) begin
                     w_state_nxt    = S_ON;
                     w_remain_nxt   = w_pend_cnt_nxt;
                     w_pend_vld_nxt = 1'b0;
                  end
`endif
               end
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they land in the same cycle as the state.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_remain <= '0;
         r_led    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_remain <= w_remain_nxt;
         r_led    <= (w_state_nxt == S_ON);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= w_done_nxt;
      end
   end

`ifdef LED_BLINKER_QUEUE_EN
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_vld <= 1'b0;
         r_pend_cnt <= '0;
      end else begin
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_cnt <= w_pend_cnt_nxt;
      end
   end
`endif

   assign led_out = r_led;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_led_blinker.sv
// Directed self-checking bench for led_blinker (ON_CYC=1000, OFF_CYC=2000).
`timescale 1ns/1ps
module tb_led_blinker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic [3:0] req_count;
   logic       led_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic led_h  [0:10000];
   logic busy_h [0:10000];
   logic done_h [0:10000];

   led_blinker #(
      .ON_MS(1), .OFF_MS(2), .CLK_FREQ_MHZ(1), .COUNT_W(4)
   ) dut (
      .clk_50MHz(clk), .rst_n(rst_n), .req(req), .req_count(req_count),
      .led_out(led_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Drive a one-cycle request; returns at the sample point of cycle 1 after the accepting edge.
   task automatic issue_req(input logic [3:0] c);
      req = 1'b1; req_count = c;
      @(posedge clk); #1;
      req = 1'b0; req_count = '0;
   endtask

   // Record n cycles of outputs (index 1 = current cycle), optionally injecting a request.
   task automatic capture(input int n, input int inj, input logic [3:0] inj_cnt);
      led_h[0] = 1'b0; busy_h[0] = 1'b0; done_h[0] = 1'b0;
      for (int i = 1; i <= n; i++) begin
         led_h[i] = led_out; busy_h[i] = busy; done_h[i] = done;
         if (i == inj) begin req = 1'b1; req_count = inj_cnt; end
         if (inj > 0 && i == inj + 1) begin req = 1'b0; req_count = '0; end
         if (i < n) begin @(posedge clk); #1; end
      end
      req = 1'b0; req_count = '0;
   endtask

   function automatic int tally(input int sel, input int a, input int b);
      int s = 0;
      for (int i = a; i <= b; i++)
         s += (sel == 0) ? int'(led_h[i]) : (sel == 1) ? int'(busy_h[i]) : int'(done_h[i]);
      return s;
   endfunction

   function automatic int rises(input int b);
      int s = 0;
      for (int i = 1; i <= b; i++) if (led_h[i] && !led_h[i-1]) s++;
      return s;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; req = 1'b0; req_count = '0;
      #2;
      checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: got %b, expected 0", led_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      capture(5000, 0, '0);
      checks++; if (tally(0, 1, 5000) !== 0) begin errors++; $display("FAIL idle_led: got %0d, expected 0", tally(0, 1, 5000)); end
      checks++; if (tally(1, 1, 5000) !== 0) begin errors++; $display("FAIL idle_busy: got %0d, expected 0", tally(1, 1, 5000)); end
      checks++; if (tally(2, 1, 5000) !== 0) begin errors++; $display("FAIL idle_done: got %0d, expected 0", tally(2, 1, 5000)); end
   endtask

   task automatic test_count3;
      issue_req(4'd3);
      capture(9100, 0, '0);
      checks++; if ({led_h[1], led_h[1000], led_h[1001], led_h[3000], led_h[3001]} !== 5'b11001) begin
         errors++; $display("FAIL c3_led_edges: got %b, expected 11001", {led_h[1], led_h[1000], led_h[1001], led_h[3000], led_h[3001]}); end
      checks++; if (tally(0, 1, 9100) !== 3000) begin errors++; $display("FAIL c3_led_total: got %0d, expected 3000", tally(0, 1, 9100)); end
      checks++; if (rises(9100) !== 3) begin errors++; $display("FAIL c3_blinks: got %0d, expected 3", rises(9100)); end
      checks++; if (tally(1, 1, 9100) !== 9000) begin errors++; $display("FAIL c3_busy_len: got %0d, expected 9000", tally(1, 1, 9100)); end
      checks++; if ({busy_h[9000], busy_h[9001]} !== 2'b10) begin errors++; $display("FAIL c3_busy_end: got %b, expected 10", {busy_h[9000], busy_h[9001]}); end
      checks++; if (tally(2, 1, 9100) !== 1) begin errors++; $display("FAIL c3_done_count: got %0d, expected 1", tally(2, 1, 9100)); end
      checks++; if (done_h[9001] !== 1'b1) begin errors++; $display("FAIL c3_done_cycle: got %b, expected 1", done_h[9001]); end
   endtask

   task automatic test_count0;
      issue_req(4'd0);
      capture(200, 0, '0);
      checks++; if (tally(1, 1, 200) !== 0) begin errors++; $display("FAIL c0_busy: got %0d, expected 0", tally(1, 1, 200)); end
      checks++; if (tally(2, 1, 200) !== 0) begin errors++; $display("FAIL c0_done: got %0d, expected 0", tally(2, 1, 200)); end
      checks++; if (tally(0, 1, 200) !== 0) begin errors++; $display("FAIL c0_led: got %0d, expected 0", tally(0, 1, 200)); end
   endtask

   task automatic test_overlap;
      int exp_blinks, exp_busy, exp_done;
`ifdef LED_BLINKER_QUEUE_EN
      exp_blinks = 3; exp_busy = 9000; exp_done = 2;
`else
      exp_blinks = 2; exp_busy = 6000; exp_done = 1;
`endif
      issue_req(4'd2);
      capture(9100, 500, 4'd1);
      checks++; if (rises(9100) !== exp_blinks) begin errors++; $display("FAIL ov_blinks: got %0d, expected %0d", rises(9100), exp_blinks); end
      checks++; if (tally(1, 1, 9100) !== exp_busy) begin errors++; $display("FAIL ov_busy_len: got %0d, expected %0d", tally(1, 1, 9100), exp_busy); end
      checks++; if (busy_h[exp_busy + 1] !== 1'b0) begin errors++; $display("FAIL ov_busy_end: got %b, expected 0", busy_h[exp_busy + 1]); end
      checks++; if (tally(2, 1, 9100) !== exp_done) begin errors++; $display("FAIL ov_done_count: got %0d, expected %0d", tally(2, 1, 9100), exp_done); end
      checks++; if (done_h[6001] !== 1'b1) begin errors++; $display("FAIL ov_first_done: got %b, expected 1", done_h[6001]); end
   endtask

   task automatic test_reset_mid;
      issue_req(4'd2);
      capture(1500, 0, '0);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_async: got %b, expected 0", busy); end
      checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL rm_led_async: got %b, expected 0", led_out); end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle_after: got %b, expected 0", busy); end
      issue_req(4'd1);
      capture(3100, 0, '0);
      checks++; if (rises(3100) !== 1) begin errors++; $display("FAIL rm_blinks: got %0d, expected 1", rises(3100)); end
      checks++; if (tally(0, 1, 3100) !== 1000) begin errors++; $display("FAIL rm_led_total: got %0d, expected 1000", tally(0, 1, 3100)); end
      checks++; if (tally(1, 1, 3100) !== 3000) begin errors++; $display("FAIL rm_busy_len: got %0d, expected 3000", tally(1, 1, 3100)); end
      checks++; if (done_h[3001] !== 1'b1) begin errors++; $display("FAIL rm_done_cycle: got %b, expected 1", done_h[3001]); end
   endtask

   task automatic test_back_to_back;
      issue_req(4'd1);
      capture(6100, 3001, 4'd1);
      checks++; if (done_h[3001] !== 1'b1) begin errors++; $display("FAIL bb_first_done: got %b, expected 1", done_h[3001]); end
      checks++; if (busy_h[3001] !== 1'b0) begin errors++; $display("FAIL bb_gap: got %b, expected 0", busy_h[3001]); end
      checks++; if (led_h[3002] !== 1'b1) begin errors++; $display("FAIL bb_restart: got %b, expected 1", led_h[3002]); end
      checks++; if (rises(6100) !== 2) begin errors++; $display("FAIL bb_blinks: got %0d, expected 2", rises(6100)); end
      checks++; if (tally(1, 1, 6100) !== 6000) begin errors++; $display("FAIL bb_busy_len: got %0d, expected 6000", tally(1, 1, 6100)); end
      checks++; if (done_h[6002] !== 1'b1) begin errors++; $display("FAIL bb_second_done: got %b, expected 1", done_h[6002]); end
      checks++; if (tally(2, 1, 6100) !== 2) begin errors++; $display("FAIL bb_done_count: got %0d, expected 2", tally(2, 1, 6100)); end
   endtask

   initial begin
      test_reset();
      test_count3();
      test_count0();
      test_overlap();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_blinker.md
# led_blinker

Output-side companion to the button debouncer: turns single-cycle event strobes into human-visible LED activity. A request carrying a blink count drives `led_out` through that many ON/OFF periods, each several milliseconds long. A `busy`/`done` pair lets the controlling FSM sequence requests. It sits between the control logic (fed by debounced button pulses) and the board LED pins.

## Interface
Parameters:
- `ON_MS`, default 200: LED-on time per blink, in ms.
- `OFF_MS`, default 200: LED-off gap after each blink, in ms.
- `CLK_FREQ_MHZ`, default 50: clock frequency, in MHz.
- `COUNT_W`, default 4: width of the blink-count field.

Ports:
- `clk_50MHz`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, 1: one-cycle request strobe, synchronous to `clk_50MHz`.
- `req_count`, input, COUNT_W: number of blinks requested; sampled with `req`.
- `led_out`, output, 1: LED drive, active-high, registered.
- `busy`, output, 1: high while a blink sequence is running.
- `done`, output, 1: one-cycle pulse when a sequence completes.

## Operation
- Derived constants:
  - ON_CYC = ON_MS*CLK_FREQ_MHZ*1000.
  - OFF_CYC = OFF_MS*CLK_FREQ_MHZ*1000.
  - Timer width is $clog2(max(ON_CYC,OFF_CYC)+1).
  - Remaining-blink counter is COUNT_W bits.
- FSM states are IDLE, ON and OFF. Reset state is IDLE.
- IDLE:
  - `req`=1 with `req_count`≠0: load remaining ← `req_count`, clear the timer, go to ON.
  - `req_count`=0: the request is ignored. No busy, no done.
- ON:
  - `led_out`=1.
  - Timer counts 0..ON_CYC-1, then the FSM goes to OFF with the timer cleared.
- OFF:
  - `led_out`=0.
  - Timer counts 0..OFF_CYC-1. On the last cycle, remaining decrements.
  - If the decremented value is ≠0, go to ON. If it is 0, go to IDLE and pulse `done`.
- `req` while busy: dropped, unless the queue feature is enabled (see Configuration).
- Outputs are registered: `led_out`=(state==ON), `busy`=(state≠IDLE).
- Reset asserted mid-sequence clears all state immediately and asynchronously: `led_out`=0, `busy`=0, `done`=0, FSM to IDLE, pending slot cleared.
- Reset values: `led_out`=0, `busy`=0, `done`=0.

## Timing
- `req` is sampled at edge k. `busy` and `led_out` rise after edge k (visible in cycle k+1).
- `led_out` is high for exactly ON_CYC cycles and low for exactly OFF_CYC cycles per blink, with no gaps or extra cycles between blinks.
- `busy` stays high for exactly N*(ON_CYC+OFF_CYC) cycles for N blinks.
- `done` is high for one cycle, in the first cycle where `busy`=0.
- A `req` that arrives in the `done` cycle is accepted, because the FSM is in IDLE. Back-to-back sequences therefore have zero idle cycles beyond that one.
- `req_count` is all-ones: the block performs 2^COUNT_W-1 blinks. There is no wrap.

## Configuration
- Macro: `LED_BLINKER_QUEUE_EN`.
- Defined: the block has a one-deep pending slot, made of a valid bit and a count.
  - A `req` with `req_count`≠0 while `busy`=1 writes the slot. A newer request overwrites an older one.
  - At the end of the final OFF period the FSM still pulses `done`. If the slot is valid, the FSM goes straight to ON with the pending count and clears the slot; `busy` stays high.
  - If `req` coincides with that final OFF cycle, the incoming request takes priority over the slot contents.
- Undefined: there is no slot. A `req` during `busy` is silently dropped.

## Test plan
All scenarios use CLK_FREQ_MHZ=1, ON_MS=1, OFF_MS=2, which gives ON_CYC=1000 and OFF_CYC=2000.
- Reset then idle: `led_out`, `busy` and `done` are 0 for 5000 cycles with no `req`.
- `req`, count=3: three 1000-cycle highs separated by 2000-cycle lows. `busy` is high for 9000 cycles. Exactly one `done` pulse, in cycle 9001 after `req`.
- `req`, count=0: no activity. `busy` and `done` stay 0.
- `req`, count=2, then a second `req`, count=1, at cycle 500:
  - Without the macro: 2 blinks and 1 `done`.
  - With the macro: 3 blinks, continuous `busy` for 9000 cycles, 2 `done` pulses.
- `rst_n` low at cycle 1500 of a count=2 sequence: `led_out` and `busy` drop asynchronously. After release the block is IDLE, and the next `req`, count=1, produces a clean single blink.
- `req`, count=1, then another `req`, count=1, in the `done` cycle: the second blink starts in the next cycle, so two blinks run back-to-back.
